// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-port bundle shared by the write arbiter and its environment.
// master drives requester words and the full flag; slave is the arbiter side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic                        full;
    logic                        w_en;
    logic [DATA_WIDTH-1:0]       wdata;
    logic [IDW-1:0]              grant_id;
    logic                        busy;

    modport master (
        output req_valid, req_data, req_last, full,
        input  req_ready, w_en, wdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, full,
        output req_ready, w_en, wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter granting N_REQ requesters access to one FIFO write port.
// A grant lasts until the owner's last word or MAX_BURST words, with one IDLE cycle between grants.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic               wclk,
    input  logic               wrst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SW  = IDW + 1;
    localparam int unsigned BCW = $clog2(MAX_BURST) + 1;

    localparam logic [IDW-1:0] LAST_ID  = IDW'(N_REQ - 1);
    localparam logic [BCW-1:0] BEAT_MAX = BCW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_q;
    logic [BCW-1:0] beat_cnt;

    logic [IDW-1:0] pick_c;
    logic           any_c;
    logic [SW-1:0]  cand;
    logic           xfer_c;
    logic           done_c;
    logic [N_REQ-1:0] rdy_c;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_c = rr_ptr;
        any_c  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + SW'(k);
            if (cand >= SW'(N_REQ)) begin
                cand = cand - SW'(N_REQ);
            end
            if (!any_c && bus.req_valid[cand[IDW-1:0]]) begin
                any_c  = 1'b1;
                pick_c = cand[IDW-1:0];
            end
        end
    end

    // Transfer and burst-end decode; a simultaneous last and beat limit ends the burst once.
    always_comb begin
        xfer_c = (state == BURST) && bus.req_valid[grant_q] && !bus.full;
        done_c = xfer_c && (bus.req_last[grant_q] || (beat_cnt == BEAT_MAX));
    end

    always_comb begin
        rdy_c = '0;
        if (state == BURST) begin
            rdy_c[grant_q] = !bus.full;
        end
    end

    assign bus.req_ready = rdy_c;
    assign bus.w_en      = xfer_c;
    assign bus.wdata     = (state == BURST)
                         ? bus.req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH]
                         : '0;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state == BURST);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_c) begin
                        grant_q  <= pick_c;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // Stalls (full or owner not valid) hold everything; no re-arbitration mid-burst.
                    if (xfer_c) begin
                        beat_cnt <= beat_cnt + BCW'(1);
                        if (done_c) begin
                            state  <= IDLE;
                            rr_ptr <= (grant_q == LAST_ID) ? '0 : grant_q + IDW'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule
